// File: rtl/iir_biquad_tdm.sv
// iir_biquad_tdm: NSEC cascaded biquad sections sharing one multiplier, one sample in flight.
// Each section takes 5 MAC cycles plus 1 round/saturate cycle.
module iir_biquad_tdm #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int NSEC   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_sat,
    input  logic                      cfg_we,
    input  logic [$clog2(5*NSEC)-1:0] cfg_addr,
    input  logic signed [COEF_W-1:0]  cfg_data,
    output logic                      cfg_err
);
    localparam int AW    = $clog2(5*NSEC);
    localparam int SW    = NSEC > 1 ? $clog2(NSEC) : 1;
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + 4;
    localparam logic [AW:0] NCOEF = (AW+1)'(5*NSEC);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC-1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] B0_RST = COEF_W'(1) << FRAC;

    typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             sec_q, sec_d;
    logic [2:0]                k_q, k_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic                      cfg_err_q;
    logic signed [COEF_W-1:0]  coef_q [5*NSEC];
    logic signed [DATA_W-1:0]  x1_q [NSEC];
    logic signed [DATA_W-1:0]  x2_q [NSEC];
    logic signed [DATA_W-1:0]  y1_q [NSEC];
    logic signed [DATA_W-1:0]  y2_q [NSEC];

    logic [AW-1:0]             idx;
    logic signed [COEF_W-1:0]  coef;
    logic signed [DATA_W-1:0]  opnd, y;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_x, rnd;
    logic                      hi, lo, last, cfg_ok;

    // Operand order per section: b0*x, b1*x1, b2*x2, a1*y1, a2*y2
    assign idx    = AW'(int'(sec_q) * 5 + int'(k_q));
    assign coef   = coef_q[idx];
    assign opnd   = k_q == 3'd0 ? x_q : k_q == 3'd1 ? x1_q[sec_q] : k_q == 3'd2 ? x2_q[sec_q] :
                    k_q == 3'd3 ? y1_q[sec_q] : y2_q[sec_q];
    assign prod   = coef * opnd;
    assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign rnd    = (acc_q + HALF) >>> FRAC;
    assign hi     = rnd > MAXV;
    assign lo     = rnd < MINV;
    assign y      = hi ? MAXV[DATA_W-1:0] : lo ? MINV[DATA_W-1:0] : rnd[DATA_W-1:0];
    assign last   = sec_q == SW'(NSEC-1);
    assign cfg_ok = cfg_we && state_q == IDLE && {1'b0, cfg_addr} < NCOEF;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == OUT;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        k_d        = k_q;
        x_d        = x_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = MAC;
                sec_d   = '0;
                k_d     = '0;
                x_d     = in_data;
                acc_d   = '0;
                sat_d   = 1'b0;
            end
            MAC: begin
                acc_d   = k_q < 3'd3 ? acc_q + prod_x : acc_q - prod_x;
                k_d     = k_q == 3'd4 ? 3'd0 : k_q + 3'd1;
                state_d = k_q == 3'd4 ? FIN : MAC;
            end
            FIN: begin
                x_d        = y;
                acc_d      = '0;
                sat_d      = sat_q | hi | lo;
                sec_d      = last ? sec_q : sec_q + 1'b1;
                state_d    = last ? OUT : MAC;
                out_data_d = last ? y : out_data_q;
                out_sat_d  = last ? sat_q | hi | lo : out_sat_q;
            end
            default: state_d = out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            k_q        <= '0;
            x_q        <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            for (int i = 0; i < NSEC; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            for (int i = 0; i < 5*NSEC; i++) coef_q[i] <= i % 5 == 0 ? B0_RST : '0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            k_q        <= k_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            cfg_err_q  <= cfg_we && !cfg_ok;
            if (cfg_ok) coef_q[cfg_addr] <= cfg_data;
            if (state_q == FIN) begin
                x2_q[sec_q] <= x1_q[sec_q];
                x1_q[sec_q] <= x_q;
                y2_q[sec_q] <= y1_q[sec_q];
                y1_q[sec_q] <= y;
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_tdm.sv
// tb_iir_biquad_tdm: directed vector table, corner sequences and a randomized run against
// an arithmetic reference model of the biquad cascade.
module tb_iir_biquad_tdm;
    localparam int DATA_W = 16, COEF_W = 16, FRAC = 14, NSEC = 2, NC = 5*NSEC, LAT = 6*NSEC;
    localparam longint YMAX = 32767, YMIN = -32768;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cfg_we = 1'b0;
    logic in_ready, out_valid, out_sat, cfg_err;
    logic signed [DATA_W-1:0] in_data = '0, out_data;
    logic [3:0] cfg_addr = '0;
    logic signed [COEF_W-1:0] cfg_data = '0;

    int n_cmp = 0, n_bad = 0;
    int mc [NC];
    int mx1 [NSEC], mx2 [NSEC], my1 [NSEC], my2 [NSEC];

    typedef struct {
        bit rst_b;
        int addr;
        int coef;
        bit smp;
        int x;
        int y;
        bit sat;
    } vec_t;
    vec_t tv [$];

    always #5 clk = ~clk;

    iir_biquad_tdm #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC), .NSEC(NSEC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) mc[i] = i % 5 == 0 ? 1 << FRAC : 0;
        for (int i = 0; i < NSEC; i++) begin
            mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
    endtask

    task automatic model_run(input int x, output int y, output bit s);
        longint acc, r;
        int v;
        v = x;
        s = 1'b0;
        for (int k = 0; k < NSEC; k++) begin
            acc = longint'(mc[5*k]) * v + longint'(mc[5*k+1]) * mx1[k] + longint'(mc[5*k+2]) * mx2[k]
                - longint'(mc[5*k+3]) * my1[k] - longint'(mc[5*k+4]) * my2[k];
            r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
            if (r > YMAX || r < YMIN) s = 1'b1;
            r = r > YMAX ? YMAX : r < YMIN ? YMIN : r;
            mx2[k] = mx1[k]; mx1[k] = v; my2[k] = my1[k]; my1[k] = int'(r);
            v = int'(r);
        end
        y = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int a, input int d, input bit exp_err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = COEF_W'(d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check($sformatf("cfg_err a=%0d", a), cfg_err, exp_err);
        if (!exp_err && a < NC) mc[a] = d;
    endtask

    task automatic send(input int x, input bit cw, input int ca, input int cd,
                        output int y, output bit s, output int lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = DATA_W'(x);
        if (cw) begin
            cfg_we = 1'b1; cfg_addr = 4'(ca); cfg_data = COEF_W'(cd);
            if (ca < NC) mc[ca] = cd;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        y = int'(out_data);
        s = out_sat;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, lat, seen;
        bit s;
        model_reset();
        tv.push_back('{1, -1, 0, 1, 1000, 1000, 0});
        tv.push_back('{0, -1, 0, 1, 32767, 32767, 0});
        tv.push_back('{0, -1, 0, 1, -32768, -32768, 0});
        tv.push_back('{1, 0, 8192, 0, 0, 0, 0});
        tv.push_back('{0, 1, 8192, 0, 0, 0, 0});
        tv.push_back('{0, 2, 8192, 0, 0, 0, 0});
        tv.push_back('{0, -1, 0, 1, 16384, 8192, 0});
        tv.push_back('{0, -1, 0, 1, 0, 8192, 0});
        tv.push_back('{0, -1, 0, 1, 0, 8192, 0});
        tv.push_back('{0, -1, 0, 1, 0, 0, 0});
        tv.push_back('{1, 3, -8192, 0, 0, 0, 0});
        tv.push_back('{0, -1, 0, 1, 1000, 1000, 0});
        tv.push_back('{0, -1, 0, 1, 0, 500, 0});
        tv.push_back('{0, -1, 0, 1, 0, 250, 0});
        tv.push_back('{0, -1, 0, 1, 0, 125, 0});
        tv.push_back('{0, -1, 0, 1, 0, 63, 0});
        tv.push_back('{1, 0, 32767, 0, 0, 0, 0});
        tv.push_back('{0, -1, 0, 1, 32767, 32767, 1});
        tv.push_back('{0, -1, 0, 1, -32768, -32768, 1});
        tv.push_back('{1, 0, 8192, 0, 0, 0, 0});
        tv.push_back('{0, -1, 0, 1, 1, 1, 0});
        tv.push_back('{0, -1, 0, 1, -1, 0, 0});

        @(posedge clk); #1;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_sat", out_sat, 0);
        check("rst cfg_err", cfg_err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst_b) do_reset();
            if (tv[i].addr >= 0) cfg_write(tv[i].addr, tv[i].coef, 1'b0);
            if (tv[i].smp) begin
                send(tv[i].x, 1'b0, 0, 0, y, s, lat);
                check($sformatf("tbl[%0d] data", i), y, tv[i].y);
                check($sformatf("tbl[%0d] sat", i), s, tv[i].sat);
                check($sformatf("tbl[%0d] latency", i), lat, LAT);
            end
        end

        // Coefficient write landing on the same edge as the sample handshake
        do_reset();
        send(1000, 1'b1, 0, 8192, y, s, lat);
        check("simul_cfg data", y, 500);
        check("simul_cfg cfg_err", cfg_err, 0);
        cfg_write(10, 123, 1'b1);
        cfg_write(15, 123, 1'b1);

        // Backpressure with a rejected write while the result is held
        do_reset();
        out_ready = 1'b0;
        send(1234, 1'b0, 0, 0, y, s, lat);
        check("bp data", y, 1234);
        check("bp latency", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'sd0;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            check("bp out_valid", out_valid, 1);
            check("bp out_data", out_data, 1234);
            check("bp in_ready", in_ready, 0);
            check("bp cfg_err", cfg_err, i == 3);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", out_valid, 0);
        send(1000, 1'b0, 0, 0, y, s, lat);
        check("bp coef kept", y, 1000);

        // Reset while holding a result
        out_ready = 1'b0;
        send(777, 1'b0, 0, 0, y, s, lat);
        check("rst_out pre", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out valid", out_valid, 0);
        check("rst_out data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of the multiply-accumulate phase
        do_reset();
        cfg_write(0, 4096, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'sd500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("abort no output", seen, 0);
        send(1000, 1'b0, 0, 0, y, s, lat);
        check("abort next data", y, 1000);
        check("abort next latency", lat, LAT);

        // Randomized coefficients, samples and write timing against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int x, ey, ca, cd, wa, wd;
            bit es, cw;
            if ($urandom_range(0, 2) == 0) begin
                wa = $urandom_range(0, 15);
                wd = wa % 5 < 3 ? int'($urandom_range(0, 32767)) - 16384 : int'($urandom_range(0, 16383)) - 8192;
                cfg_write(wa, wd, wa >= NC);
            end
            cw = $urandom_range(0, 3) == 0;
            ca = $urandom_range(0, NC-1);
            cd = ca % 5 < 3 ? int'($urandom_range(0, 32767)) - 16384 : int'($urandom_range(0, 16383)) - 8192;
            x = int'($urandom_range(0, 65535)) - 32768;
            send(x, cw, ca, cd, y, s, lat);
            model_run(x, ey, es);
            check($sformatf("rnd[%0d] data x=%0d", i, x), y, ey);
            check($sformatf("rnd[%0d] sat", i), s, es);
            check($sformatf("rnd[%0d] latency", i), lat, LAT);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
